// File: rtl/half_pkg.sv
// Shared binary16 definitions for the half-precision vector stages.
package half_pkg;

  typedef logic [15:0] half_t;

  localparam half_t HALF_NEG_INF = 16'hFC00;
  localparam half_t HALF_ZERO    = 16'h0000;

  typedef enum logic [1:0] {
    COLLECT_IDLE,
    COLLECT_OUT,
    COLLECT_FULL
  } collect_state_t;

endpackage

// File: rtl/half_vector_collect_if.sv
// Stream-in / vector-out handshake bundle for half_vector_collect.
// HALF_VECTOR_COLLECT_FLUSH_EN adds the in_last short-vector marker.
interface half_vector_collect_if #(
  parameter int WIDTH = 16
);

  logic                in_valid;
  logic                in_ready;
  half_pkg::half_t     in_data;
`ifdef HALF_VECTOR_COLLECT_FLUSH_EN
  logic                in_last;
`endif
  logic                out_valid;
  logic                out_ready;
  half_pkg::half_t     out_vector [WIDTH];

  modport master (
    output in_valid, in_data,
`ifdef HALF_VECTOR_COLLECT_FLUSH_EN
    output in_last,
`endif
    output out_ready,
    input  in_ready, out_valid, out_vector
  );

  modport slave (
    input  in_valid, in_data,
`ifdef HALF_VECTOR_COLLECT_FLUSH_EN
    input  in_last,
`endif
    input  out_ready,
    output in_ready, out_valid, out_vector
  );

endinterface

// File: rtl/half_vector_bank.sv
// WIDTH x binary16 register bank: single-lane write, whole-bank load,
// and padding of every lane above lane_idx with HALF_NEG_INF.
module half_vector_bank
  import half_pkg::*;
#(
  parameter  int WIDTH  = 16,
  localparam int LANE_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lane_we,
  input  logic [LANE_W-1:0] lane_idx,
  input  half_t             lane_data,
  input  logic              pad_en,
  input  logic              load_en,
  input  half_t             load_data [WIDTH],
  output half_t             q [WIDTH]
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) q[i] <= HALF_ZERO;
    end else if (load_en) begin
      q <= load_data;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (lane_we && LANE_W'(i) == lane_idx) q[i] <= lane_data;
        else if (pad_en && LANE_W'(i) > lane_idx) q[i] <= HALF_NEG_INF;
      end
    end
  end

endmodule

// File: rtl/half_vector_collect.sv
// Packs a serial binary16 stream into WIDTH-lane vectors, double buffered.
// HALF_VECTOR_COLLECT_FLUSH_EN enables in_last early completion with -inf padding.
module half_vector_collect
  import half_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst,
  half_vector_collect_if.slave  bus
);

  localparam int                LANE_W    = $clog2(WIDTH);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WIDTH - 1);

  collect_state_t    state, state_next;
  logic [LANE_W-1:0] lane_cnt;
  logic              accept, last, complete, out_load;
  half_t             fill_q    [WIDTH];
  half_t             out_q     [WIDTH];
  half_t             assembled [WIDTH];
  half_t             load_data [WIDTH];

`ifdef HALF_VECTOR_COLLECT_FLUSH_EN
  assign last = bus.in_last;
`else
  assign last = 1'b0;
`endif

  assign bus.in_ready   = !rst && (state != COLLECT_FULL);
  assign bus.out_valid  = (state != COLLECT_IDLE);
  assign bus.out_vector = out_q;
  assign accept         = bus.in_valid && bus.in_ready;
  assign complete       = accept && (last || lane_cnt == LAST_LANE);

  // Fill bank contents with the incoming lane merged in, for direct hand-off.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      if (LANE_W'(i) == lane_cnt) assembled[i] = bus.in_data;
      else if (last && LANE_W'(i) > lane_cnt) assembled[i] = HALF_NEG_INF;
      else assembled[i] = fill_q[i];
    end
  end

  always_comb begin
    state_next = state;
    out_load   = 1'b0;
    load_data  = assembled;
    case (state)
      COLLECT_IDLE: begin
        if (complete) begin
          state_next = COLLECT_OUT;
          out_load   = 1'b1;
        end
      end
      COLLECT_OUT: begin
        if (complete && bus.out_ready) out_load = 1'b1;
        else if (complete) state_next = COLLECT_FULL;
        else if (bus.out_ready) state_next = COLLECT_IDLE;
      end
      COLLECT_FULL: begin
        if (bus.out_ready) begin
          state_next = COLLECT_OUT;
          out_load   = 1'b1;
          load_data  = fill_q;
        end
      end
      default: state_next = COLLECT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           lane_cnt <= '0;
    else if (complete) lane_cnt <= '0;
    else if (accept)   lane_cnt <= lane_cnt + 1'b1;
  end

  // Every accepted lane lands in the fill bank; it only matters when the output is busy.
  half_vector_bank #(.WIDTH(WIDTH)) u_fill_bank (
    .clk       (clk),
    .rst       (rst),
    .lane_we   (accept),
    .lane_idx  (lane_cnt),
    .lane_data (bus.in_data),
    .pad_en    (accept && last),
    .load_en   (1'b0),
    .load_data (assembled),
    .q         (fill_q)
  );

  half_vector_bank #(.WIDTH(WIDTH)) u_out_bank (
    .clk       (clk),
    .rst       (rst),
    .lane_we   (1'b0),
    .lane_idx  (lane_cnt),
    .lane_data (bus.in_data),
    .pad_en    (1'b0),
    .load_en   (out_load),
    .load_data (load_data),
    .q         (out_q)
  );

endmodule

// File: tb/tb_half_vector_collect.sv
// Randomized self-checking bench for half_vector_collect against a queue-based model.
// Builds with WIDTH=5 and flush checks when HALF_VECTOR_COLLECT_FLUSH_EN is defined.
module tb_half_vector_collect;
  import half_pkg::*;

`ifdef HALF_VECTOR_COLLECT_FLUSH_EN
  localparam int W = 5;
`else
  localparam int W = 16;
`endif

  typedef half_t vec_t [W];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  half_vector_collect_if #(.WIDTH(W)) bus ();

  half_vector_collect #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  vec_t exp_q [$];
  vec_t part;
  int   part_n = 0;
  int   checks = 0;
  int   passes = 0;
  bit   run_cmp = 1'b0;
  bit   m_acc, m_last;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Model: completed vectors queue up; the head is what out_vector must show.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      part_n = 0;
    end else begin
      m_acc  = bus.in_valid && (exp_q.size() < 2);
      m_last = 1'b0;
`ifdef HALF_VECTOR_COLLECT_FLUSH_EN
      m_last = bus.in_last;
`endif
      if (exp_q.size() > 0 && bus.out_ready) void'(exp_q.pop_front());
      if (m_acc) begin
        part[part_n] = bus.in_data;
        part_n++;
        if (part_n == W || m_last) begin
          for (int i = part_n; i < W; i++) part[i] = HALF_NEG_INF;
          exp_q.push_back(part);
          part_n = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      check_output("in_ready", 16'(bus.in_ready), 16'(!rst && exp_q.size() < 2));
      check_output("out_valid", 16'(bus.out_valid), 16'(exp_q.size() > 0));
      if (exp_q.size() > 0)
        for (int i = 0; i < W; i++)
          check_output($sformatf("out_vector[%0d]", i), bus.out_vector[i], exp_q[0][i]);
    end
  end

  task automatic apply_stimulus(input half_t v, input bit l);
    int n;
    bit rdy;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
`ifdef HALF_VECTOR_COLLECT_FLUSH_EN
    bus.in_last  = l;
`else
    if (l) $display("[TB] in_last ignored without flush build");
`endif
    forever begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 200) begin
        check_output("accept_timeout", 16'(0), 16'(1));
        break;
      end
    end
    bus.in_valid = 1'b0;
`ifdef HALF_VECTOR_COLLECT_FLUSH_EN
    bus.in_last  = 1'b0;
`endif
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef HALF_VECTOR_COLLECT_FLUSH_EN
    bus.in_last   = 1'b0;
`endif
    run_cmp = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset out_vector[0]", bus.out_vector[0], 16'h0000);
    check_output("reset in_ready", 16'(bus.in_ready), 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;

    $display("[TB] single vector");
    for (int i = 0; i < W; i++) apply_stimulus(half_t'(16'h3C00 + i), 1'b0);
    @(negedge clk);
    check_output("single out_valid", 16'(bus.out_valid), 16'h0001);
    for (int i = 0; i < W; i++)
      check_output("single lane", bus.out_vector[i], half_t'(16'h3C00 + i));
    @(negedge clk);
    check_output("single pulse end", 16'(bus.out_valid), 16'h0000);
    @(posedge clk);
    #1;

    $display("[TB] back-to-back");
    for (int i = 0; i < 3 * W; i++) apply_stimulus(half_t'($urandom), 1'b0);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2 * W; i++) apply_stimulus(half_t'(16'h4000 + i), 1'b0);
    @(negedge clk);
    check_output("bp in_ready", 16'(bus.in_ready), 16'h0000);
    check_output("bp held lane0", bus.out_vector[0], 16'h4000);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_output("bp second lane0", bus.out_vector[0], half_t'(16'h4000 + W));
    check_output("bp in_ready back", 16'(bus.in_ready), 16'h0001);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] random gaps");
    for (int i = 0; i < 4 * W; i++) begin
      bus.out_ready = 1'($urandom_range(1, 0));
      if ($urandom_range(1, 0) == 1) begin
        @(posedge clk);
        #1;
      end
      apply_stimulus(half_t'($urandom), 1'b0);
    end
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset mid-vector");
    for (int i = 0; i < 5; i++) apply_stimulus(half_t'(16'h6000 + i), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_output("rst out_valid", 16'(bus.out_valid), 16'h0000);
    for (int i = 0; i < W; i++) check_output("rst lane", bus.out_vector[i], 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < W; i++) apply_stimulus(half_t'(16'h5000 + i), 1'b0);
    @(negedge clk);
    check_output("post-rst lane0", bus.out_vector[0], 16'h5000);
    check_output("post-rst last lane", bus.out_vector[W-1], half_t'(16'h5000 + W - 1));
    @(posedge clk);
    #1;

`ifdef HALF_VECTOR_COLLECT_FLUSH_EN
    $display("[TB] flush");
    apply_stimulus(16'h4000, 1'b0);
    apply_stimulus(16'h4200, 1'b0);
    apply_stimulus(16'h4400, 1'b1);
    @(negedge clk);
    check_output("flush lane0", bus.out_vector[0], 16'h4000);
    check_output("flush lane1", bus.out_vector[1], 16'h4200);
    check_output("flush lane2", bus.out_vector[2], 16'h4400);
    check_output("flush lane3", bus.out_vector[3], 16'hFC00);
    check_output("flush lane4", bus.out_vector[4], 16'hFC00);
    @(posedge clk);
    #1;
    for (int i = 0; i < W; i++) apply_stimulus(half_t'(16'h7000 + i), 1'b0);
    @(negedge clk);
    check_output("after flush lane0", bus.out_vector[0], 16'h7000);
    @(posedge clk);
    #1;
`endif

    repeat (3) @(posedge clk);
    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
